gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Self-checking stimulus generator for the 5-input gate block (y = ((a & b) ^ (c | d)) | e). It sits on the opposite side of the gate's interface: it drives all 32 input combinations onto the gate's inputs and samples the gate's output. Each sample is compared against an internal golden model. Pass/fail, the error count and the first failing vector are reported. It is used as an on-chip built-in self-test and as a bench driver.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: number of wait cycles between driving a vector and sampling i_y (0 allowed).
- ERR_W, default 6: width of the error counter. The maximum count is 32, so ERR_W ≥ 6 is required.

Ports:
- i_clk  in  1  the single clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start request, sampled only in IDLE
- i_y  in  1  output of the gate under test
- o_a, o_b, o_c, o_d, o_e  out  1 each  gate stimulus
- o_busy  out  1  run in progress
- o_done  out  1  one-cycle pulse at the end of a run
- o_pass  out  1  1 when the last completed run had zero mismatches
- o_err_cnt  out  ERR_W  mismatch count of the current or last run
- o_fail_valid  out  1  at least one mismatch seen
- o_fail_vec  out  5  first failing vector {a,b,c,d,e}, a = MSB

Clocking and reset:
- One clock domain: i_clk.
- Reset is synchronous and active-high (i_rst).

## Operation
- Internal 5-bit vector counter `vec`. Stimulus is {o_a,o_b,o_c,o_d,o_e} = vec, with o_a as the MSB.
- Golden value: exp = ((vec[4] & vec[3]) ^ (vec[2] | vec[1])) | vec[0].
- FSM states are IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE: stimulus = 0 and o_busy = 0. When i_start = 1, go to DRIVE. On that transition, set vec = 0, o_err_cnt = 0, o_fail_valid = 0, o_fail_vec = 0 and o_pass = 0.
  - DRIVE: lasts 1 cycle. Stimulus = vec. Go to SETTLE, or go directly to CHECK when SETTLE_CYCLES = 0.
  - SETTLE: lasts SETTLE_CYCLES cycles, counted by a settle counter. Stimulus is held.
  - CHECK: lasts 1 cycle.
    - Compare i_y with exp.
    - On mismatch, increment o_err_cnt. If o_fail_valid = 0, set o_fail_vec = vec and o_fail_valid = 1.
    - If vec = 31, go to DONE. Otherwise increment vec and go to DRIVE.
  - DONE: lasts 1 cycle.
    - o_done = 1, stimulus = 0.
    - o_pass is loaded with (final error count == 0); this includes a mismatch counted in the last CHECK.
    - Go to IDLE.
- o_busy = 1 in DRIVE, SETTLE, CHECK and DONE.
- o_pass, o_err_cnt, o_fail_valid and o_fail_vec hold their values in IDLE until the next accepted start.
- i_start outside IDLE is ignored and does not restart or extend the run.
- A mismatch never aborts the run; all 32 vectors are always applied.

## Timing
- Reset value of every output is 0. This applies to stimulus, o_busy, o_done, o_pass, o_err_cnt, o_fail_valid and o_fail_vec.
- Let i_start be sampled high in IDLE at the edge ending cycle t, and let S = SETTLE_CYCLES.
  - Vector v is driven during cycles t+1+v·(S+2) through t+(v+1)·(S+2).
  - i_y is sampled in the last cycle of each vector's window.
  - o_done pulses in cycle t+1+32·(S+2): t+129 when S = 2, t+65 when S = 0.
  - o_busy is high from t+1 through the o_done cycle inclusive.
  - A new start is accepted at the earliest in the cycle after o_done.
- Reset during a run takes effect at the next edge:
  - The FSM returns to IDLE and all outputs go to 0.
  - No o_done pulse is produced.
  - Partial results are discarded.
- i_rst and i_start high together: reset wins.

## Structure
- Package gate_pkg contains:
  - the FSM state enum;
  - N_VEC = 32 and the vector width 5;
  - function gate_expected(vec), the golden equation, shared with benches.
- Single module. No sub-module is needed; the vector counter and settle counter are inline.

## Test plan
- i_y wired to a correct gate model, S = 2, pulse i_start → o_done at t+129, o_pass = 1, o_err_cnt = 0, o_fail_valid = 0.
- i_y tied to 0 → o_err_cnt = 26, o_fail_vec = 5'b00001, o_pass = 0.
- i_y tied to 1 → o_err_cnt = 6, o_fail_vec = 5'b00000, o_fail_valid = 1.
- Correct model but i_y inverted only while vec = 21 → o_err_cnt = 1, o_fail_vec = 5'b10101. A follow-up clean run → o_pass = 1, counters cleared.
- Assert i_rst while vec = 10 → the next cycle has all outputs 0, and no o_done pulse occurs. A subsequent start completes a full 32-vector run with correct timing.
- S = 0, with i_start held high throughout the run → o_done at t+65, exactly one run before a re-accept; the next run starts the cycle after o_done.

Source files
------------

// File: rtl/gate_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_pkg : shared types, sizes and the golden equation of the 5-input gate
// Revision : 1.0
// ---------------------------------------------------------------------------
package gate_pkg;

    localparam int N_VEC = 32;
    localparam int VEC_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } gate_state_t;

    // vec = {a,b,c,d,e}, a is the MSB
    function automatic logic gate_expected(input logic [VEC_W-1:0] vec);
        return ((vec[4] & vec[3]) ^ (vec[2] | vec[1])) | vec[0];
    endfunction

endpackage : gate_pkg
`default_nettype wire

// File: rtl/gate_exerciser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_exerciser : walks all 32 input vectors through the gate under test
//                  and scores its output against the golden equation.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module gate_exerciser
    import gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_y,
    output logic             o_a,
    output logic             o_b,
    output logic             o_c,
    output logic             o_d,
    output logic             o_e,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_fail_valid,
    output logic [VEC_W-1:0] o_fail_vec
);

    localparam int               c_SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [VEC_W-1:0] c_VEC_LAST = VEC_W'(N_VEC - 1);

    gate_state_t        r_state;
    logic [VEC_W-1:0]   r_vec;
    logic [c_SET_W-1:0] r_set_cnt;
    logic [VEC_W-1:0]   r_stim;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               r_fail_valid;
    logic [VEC_W-1:0]   r_fail_vec;

    logic               w_mismatch;
    logic [ERR_W-1:0]   w_err_next;

    // The count including the current CHECK lets the last vector's miss reach o_pass
    assign w_mismatch = (i_y != gate_expected(r_vec));
    assign w_err_next = r_err_cnt + ERR_W'(w_mismatch);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_set_cnt    <= '0;
            r_stim       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    r_stim <= '0;
                    if (i_start) begin
                        r_state      <= ST_DRIVE;
                        r_busy       <= 1'b1;
                        r_vec        <= '0;
                        r_err_cnt    <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
                        r_pass       <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    r_set_cnt <= '0;
                    if (SETTLE_CYCLES == 0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_set_cnt == c_SET_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_set_cnt <= r_set_cnt + c_SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    r_err_cnt <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_vec   <= r_vec;
                    end
                    if (r_vec == c_VEC_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_stim  <= '0;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_vec   <= r_vec + VEC_W'(1);
                        r_stim  <= r_vec + VEC_W'(1);
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_a          = r_stim[4];
    assign o_b          = r_stim[3];
    assign o_c          = r_stim[2];
    assign o_d          = r_stim[1];
    assign o_e          = r_stim[0];
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_cnt    = r_err_cnt;
    assign o_fail_valid = r_fail_valid;
    assign o_fail_vec   = r_fail_vec;

endmodule : gate_exerciser
`default_nettype wire

// File: tb/tb_gate_exerciser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gate_exerciser : directed runs against a behavioural gate, S=2 and S=0
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_gate_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic start2 = 1'b0;
    logic start0 = 1'b0;
    int   mode   = 0;
    logic sel    = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0] err;
        logic       fv;
        logic [4:0] fvec;
        logic       pass;
    } res_t;
    res_t sb[$];

    logic       a2, b2, c2, d2, e2, busy2, done2, pass2, fv2, y2;
    logic [5:0] err2;
    logic [4:0] fvec2;
    logic       a0, b0, c0, d0, e0, busy0, done0, pass0, fv0, y0;
    logic [5:0] err0;
    logic [4:0] fvec0;

    logic [4:0] obs_stim, obs_fvec;
    logic [5:0] obs_err;
    logic       obs_busy, obs_done, obs_pass, obs_fv;

    function automatic logic golden(input logic [4:0] v);
        logic ab, cd;
        ab = v[4] & v[3];
        cd = v[2] | v[1];
        return (ab != cd) || v[0];
    endfunction

    function automatic logic gate_model(input int m, input logic [4:0] v);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (v == 5'd21) ? ~golden(v) : golden(v);
            default: return golden(v);
        endcase
    endfunction

    always_comb y2 = gate_model(mode, {a2, b2, c2, d2, e2});
    always_comb y0 = gate_model(mode, {a0, b0, c0, d0, e0});

    always_comb begin
        if (sel) begin
            obs_stim = {a0, b0, c0, d0, e0};
            obs_busy = busy0; obs_done = done0; obs_pass = pass0;
            obs_err  = err0;  obs_fv   = fv0;   obs_fvec = fvec0;
        end else begin
            obs_stim = {a2, b2, c2, d2, e2};
            obs_busy = busy2; obs_done = done2; obs_pass = pass2;
            obs_err  = err2;  obs_fv   = fv2;   obs_fvec = fvec2;
        end
    end

    gate_exerciser #(.SETTLE_CYCLES(2), .ERR_W(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_y(y2),
        .o_a(a2), .o_b(b2), .o_c(c2), .o_d(d2), .o_e(e2),
        .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_cnt(err2),
        .o_fail_valid(fv2), .o_fail_vec(fvec2)
    );

    gate_exerciser #(.SETTLE_CYCLES(0), .ERR_W(6)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_y(y0),
        .o_a(a0), .o_b(b0), .o_c(c0), .o_d(d0), .o_e(e0),
        .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_cnt(err0),
        .o_fail_valid(fv0), .o_fail_vec(fvec0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stim"}, obs_stim, 0);
        chk({tag, "_busy"}, obs_busy, 0);
        chk({tag, "_done"}, obs_done, 0);
        chk({tag, "_pass"}, obs_pass, 0);
        chk({tag, "_err"},  obs_err,  0);
        chk({tag, "_fv"},   obs_fv,   0);
        chk({tag, "_fvec"}, obs_fvec, 0);
    endtask

    // Expected end-of-run result, derived by walking the vectors through the model
    task automatic push_expected(input int m);
        res_t r;
        r.err = '0; r.fv = 1'b0; r.fvec = '0;
        for (int v = 0; v < 32; v++) begin
            if (gate_model(m, 5'(v)) != golden(5'(v))) begin
                r.err++;
                if (!r.fv) begin
                    r.fv   = 1'b1;
                    r.fvec = 5'(v);
                end
            end
        end
        r.pass = (r.err == 0);
        sb.push_back(r);
    endtask

    task automatic set_start(input logic v);
        if (sel) start0 = v; else start2 = v;
    endtask

    // Called at a negedge in IDLE (or in the DONE cycle when gap=1, start held).
    task automatic do_run(input bit s0, input int m, input bit hold, input bit gap);
        int   per, total;
        res_t r;
        per   = s0 ? 2 : 4;
        total = 32 * per;
        sel   = s0;
        mode  = m;
        push_expected(m);
        set_start(1'b1);
        if (gap) begin
            @(negedge clk);
            chk("gap_busy", obs_busy, 0);
            chk("gap_done", obs_done, 0);
        end
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            if (!hold && k == 1) set_start(1'b0);
            if (k <= total) begin
                chk("run_busy", obs_busy, 1);
                chk("run_stim", obs_stim, (k - 1) / per);
                chk("run_done", obs_done, 0);
            end else begin
                chk("end_done", obs_done, 1);
                chk("end_busy", obs_busy, 1);
                chk("end_stim", obs_stim, 0);
                r = sb.pop_front();
                chk("end_err",  obs_err,  r.err);
                chk("end_fv",   obs_fv,   r.fv);
                chk("end_fvec", obs_fvec, r.fvec);
                chk("end_pass", obs_pass, r.pass);
            end
        end
    endtask

    task automatic idle_after_run(input bit s0);
        sel = s0;
        @(negedge clk);
        chk("post_busy", obs_busy, 0);
        chk("post_done", obs_done, 0);
    endtask

    initial begin
        int   ndone;
        bit   hit;
        repeat (3) @(negedge clk);
        sel = 1'b0; chk_zero("rst2");
        sel = 1'b1; chk_zero("rst0");
        rst = 1'b0;
        @(negedge clk);

        // S=2: correct gate, tie-0, tie-1, single inversion at 21, clean rerun
        do_run(1'b0, 0, 1'b0, 1'b0); idle_after_run(1'b0);
        do_run(1'b0, 1, 1'b0, 1'b0); idle_after_run(1'b0);
        chk("hold_err", obs_err, 26);
        do_run(1'b0, 2, 1'b0, 1'b0); idle_after_run(1'b0);
        do_run(1'b0, 3, 1'b0, 1'b0); idle_after_run(1'b0);
        do_run(1'b0, 0, 1'b0, 1'b0); idle_after_run(1'b0);

        // Reset in the middle of vector 10
        mode = 0; sel = 1'b0;
        start2 = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (obs_busy && obs_stim == 5'd10) hit = 1'b1;
        end
        chk("reach_vec10", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("midrst");
        ndone = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (obs_done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        do_run(1'b0, 0, 1'b0, 1'b0); idle_after_run(1'b0);

        // Reset and start together: reset wins
        rst = 1'b1; start2 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start2 = 1'b0;
        chk("rst_start_busy", obs_busy, 0);
        @(negedge clk);
        chk("rst_start_busy2", obs_busy, 0);

        // S=0 with start held: two back-to-back runs separated by one IDLE cycle
        do_run(1'b1, 0, 1'b1, 1'b0);
        do_run(1'b1, 0, 1'b0, 1'b1);
        idle_after_run(1'b1);
        chk("s0_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gate_exerciser
`default_nettype wire
